_mem_stage: RTL and testbench
=============================

Name: _mem_stage

Overview:
- Memory-access stage of the 32-bit five-stage pipeline. It sits between EX and the MEM/WB register and holds the EX/MEM pipeline register, the data memory, and the load/store datapath.
- It performs byte, halfword and word loads and stores (little-endian), plus sign/zero extension and alignment checking.
- Its outputs feed the MEM/WB register inputs directly (ReadData, AluRes, Rd, RegWrite, MemToReg).

Parameters:
- ADDR_W, 8, data memory depth is 2^ADDR_W words of 32 bits. Byte address bits [ADDR_W+1:2] select the word.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the EX/MEM register contents (hazard unit).
- flush  input  1  load a bubble into the EX/MEM register.
- AluRes_in  input  32  ALU result from EX; effective address for loads/stores.
- WriteData_in  input  32  store data (rt value) from EX.
- Rd_in  input  5  destination register from EX.
- RegWrite_in  input  1  RegWrite control from EX.
- MemToReg_in  input  1  MemToReg control from EX.
- MemRead_in  input  1  load control from EX.
- MemWrite_in  input  1  store control from EX.
- Size_in  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- Unsigned_in  input  1  1 = zero-extend loads, 0 = sign-extend loads.
- ReadData  output  32  extended load data, to MEM/WB.
- AluRes  output  32  registered ALU result, to MEM/WB.
- Rd  output  5  registered destination register, to MEM/WB.
- RegWrite  output  1  registered RegWrite (gated), to MEM/WB.
- MemToReg  output  1  registered MemToReg, to MEM/WB.
- Misaligned  output  1  current access is misaligned.

Behaviour:
- EX/MEM register update at posedge clk, priority reset > flush > stall > capture:
  - reset (async) and flush clear all fields to 0, including every control bit.
  - stall holds every field unchanged.
  - otherwise all *_in fields are captured.
- Reset values: AluRes=0, Rd=0, RegWrite=0, MemToReg=0, ReadData=0, Misaligned=0. Memory contents are not reset.
- Index: idx = AluRes[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- Byte offset: off = AluRes[1:0].
- Misalignment condition, mis:
  - half with off[0]=1, or word (10/11) with off!=00;
  - evaluated only when registered MemRead or MemWrite is 1.
  - Misaligned = mis, combinational from the registered fields.
- Read path is combinational from the registered address, so ReadData is valid in the same cycle the instruction sits in the register. Latency from *_in to outputs is one clock.
  - Byte: lane off selected; half: bytes off+1:off; word: the full word.
  - Extension per Unsigned.
  - ReadData=0 when MemRead=0 or mis=1.
- Write path: at posedge clk, if registered MemWrite=1 and mis=0, the selected lanes of mem[idx] are updated.
  - Byte uses WriteData[7:0] and half uses WriteData[15:0], placed at off. Other lanes are preserved.
  - A store held by stall rewrites the same value, which is idempotent.
  - A store whose register is being flushed still commits on that edge. Flush affects only the next contents.
- RegWrite output = registered RegWrite AND NOT (MemRead AND mis): a misaligned load never writes the register file. AluRes, Rd and MemToReg pass through unchanged.
- Store followed immediately by a load to the same word: the load observes the new data, because the write commits at the edge that moves the load into the register.
- Simultaneous MemRead and MemWrite: both are performed. ReadData shows the pre-write contents during that cycle.
- Reset asserted mid-store: the register clears asynchronously, so no write occurs at any later edge. Memory keeps its prior contents.

Test Plan:
- Word store then load:
  - Stimulus: store 0xDEADBEEF at addr 0x10, next cycle load word from 0x10.
  - Required: ReadData=0xDEADBEEF, RegWrite=1, MemToReg=1, Rd as issued.
- Byte/half extension:
  - Stimulus: store word 0x80F17F01 at 0x20, then loads at 0x22 byte signed, 0x22 byte unsigned, 0x22 half signed, 0x20 half unsigned.
  - Required: 0xFFFFFFF1, 0x000000F1, 0xFFFF80F1, 0x00007F01.
- Sub-word store merge:
  - Stimulus: word 0x11223344 at 0x30, then byte store 0xAA at 0x31, then half store 0xBEEF at 0x32, then word load 0x30.
  - Required: ReadData=0xBEEFAA44.
- Misalignment:
  - Stimulus: word load at 0x41, half store at 0x43 (memory word at 0x40 preloaded 0x12345678).
  - Required: Misaligned=1, ReadData=0, RegWrite=0 on the load; memory word 0x40 still 0x12345678.
- Stall/flush:
  - Stimulus: capture ALU op Rd=5, RegWrite=1, AluRes=0x7, then hold stall for 2 cycles while inputs change.
  - Required: outputs remain Rd=5, AluRes=0x7.
  - Stimulus: then assert flush.
  - Required: next cycle all controls 0, Rd=0.
- Async reset and wrap:
  - Stimulus: assert reset mid-cycle with a store pending.
  - Required: outputs 0 immediately, target word unchanged.
  - Stimulus: with ADDR_W=8, store at 0x404 then load at 0x004.
  - Required: load returns the stored value.

Source files
------------

// File: rtl/_mem_stage.sv
// Memory-access stage: EX/MEM pipeline register, word-organised data memory,
// and the little-endian byte/half/word load-store datapath with alignment check.
module _mem_stage #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] AluRes_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  Rd_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  Size_in,
    input  logic        Unsigned_in,
    output logic [31:0] ReadData,
    output logic [31:0] AluRes,
    output logic [4:0]  Rd,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        Misaligned
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned DATA_W = 32;

    // EX/MEM register fields
    logic [DATA_W-1:0] alu_q,      alu_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [4:0]        rd_q,       rd_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic [1:0]        size_q,     size_d;
    logic              unsigned_q, unsigned_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [4:0]        lane_sh;
    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              mis_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] merged_c;

    // Next-state for the EX/MEM register: flush beats stall beats capture
    always_comb begin
        alu_d      = alu_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        if (flush) begin
            alu_d      = '0;
            wdata_d    = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            size_d     = '0;
            unsigned_d = 1'b0;
        end else if (!stall) begin
            alu_d      = AluRes_in;
            wdata_d    = WriteData_in;
            rd_d       = Rd_in;
            regwrite_d = RegWrite_in;
            memtoreg_d = MemToReg_in;
            memread_d  = MemRead_in;
            memwrite_d = MemWrite_in;
            size_d     = Size_in;
            unsigned_d = Unsigned_in;
        end
    end

    // EX/MEM register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
        end else begin
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
        end
    end

    // Address decode and alignment check on the registered access
    always_comb begin
        idx      = alu_q[ADDR_W+1:2];
        off      = alu_q[1:0];
        lane_sh  = {off, 3'b000};
        is_byte  = (size_q == 2'b00);
        is_half  = (size_q == 2'b01);
        is_word  = size_q[1];
        mis_c    = (memread_q | memwrite_q) &
                   ((is_half & off[0]) | (is_word & (off != 2'b00)));
        mem_we_c = memwrite_q & ~mis_c;
    end

    // Load path: lane select plus sign/zero extension, zero when idle or misaligned
    always_comb begin
        cur_word = mem_q[idx];
        shifted  = cur_word >> lane_sh;
        load_c   = '0;
        if (memread_q && !mis_c) begin
            if (is_byte) begin
                load_c = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
            end else if (is_half) begin
                load_c = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
            end else begin
                load_c = cur_word;
            end
        end
    end

    // Store merge: replicate the store data across lanes and mask in the target bytes
    always_comb begin
        wr_mask = '1;
        wr_data = wdata_q;
        if (is_byte) begin
            wr_mask = DATA_W'(32'h0000_00FF) << lane_sh;
            wr_data = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            wr_mask = DATA_W'(32'h0000_FFFF) << lane_sh;
            wr_data = {2{wdata_q[15:0]}};
        end
        merged_c = (cur_word & ~wr_mask) | (wr_data & wr_mask);
    end

    // Data memory write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx] <= merged_c;
        end
    end

    assign ReadData   = load_c;
    assign AluRes     = alu_q;
    assign Rd         = rd_q;
    assign RegWrite   = regwrite_q & ~(memread_q & mis_c);
    assign MemToReg   = memtoreg_q;
    assign Misaligned = mis_c;

endmodule

// File: tb/tb__mem_stage.sv
// Scoreboard bench for _mem_stage: byte-level reference memory, random and directed traffic.
module tb__mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] AluRes_in, WriteData_in;
    logic [4:0]  Rd_in;
    logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
    logic [1:0]  Size_in;
    logic        Unsigned_in;
    logic [31:0] ReadData, AluRes;
    logic [4:0]  Rd;
    logic        RegWrite, MemToReg, Misaligned;

    always #5 clk = ~clk;

    _mem_stage #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .AluRes_in(AluRes_in), .WriteData_in(WriteData_in), .Rd_in(Rd_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Size_in(Size_in), .Unsigned_in(Unsigned_in),
        .ReadData(ReadData), .AluRes(AluRes), .Rd(Rd), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .Misaligned(Misaligned)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw, m2r, mr, mw;
        logic [1:0]  size;
        logic        uns;
    } instr_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw, m2r, mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mbytes [1024];   // byte-addressed reference memory (1 KiB, wraps)
    instr_t      cur;             // instruction the register should hold
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit is_mis(input instr_t i);
        return (i.mr || i.mw) && ((i.alu % 32'(nb(i.size))) != 32'd0);
    endfunction

    function automatic int baddr(input logic [31:0] a);
        return int'(a % 32'd1024);
    endfunction

    task automatic model_commit(input instr_t i);
        if (i.mw && !is_mis(i))
            for (int k = 0; k < nb(i.size); k++)
                mbytes[baddr(i.alu) + k] = i.wd[8*k +: 8];
    endtask

    function automatic exp_t expect_of(input instr_t i);
        exp_t        e;
        logic [31:0] v;
        int          n;
        bit          m;
        n = nb(i.size);
        m = is_mis(i);
        v = '0;
        if (i.mr && !m) begin
            for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[baddr(i.alu) + k];
            if (!i.uns && n < 4 && v[8*n-1])
                for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        e.rdata = v;
        e.alu   = i.alu;
        e.rd    = i.rd;
        e.rw    = i.rw && !(i.mr && m);
        e.m2r   = i.m2r;
        e.mis   = m;
        return e;
    endfunction

    // Advance the reference by one clock: commit whatever sits in the register, then load the next
    task automatic step(input instr_t ins, input bit st, input bit fl, input bit rs);
        if (!rs) model_commit(cur);
        if (rs || fl)   cur = '0;
        else if (!st)   cur = ins;
        exp_q.push_back(expect_of(cur));
    endtask

    task automatic drive(input instr_t ins);
        AluRes_in    = ins.alu;
        WriteData_in = ins.wd;
        Rd_in        = ins.rd;
        RegWrite_in  = ins.rw;
        MemToReg_in  = ins.m2r;
        MemRead_in   = ins.mr;
        MemWrite_in  = ins.mw;
        Size_in      = ins.size;
        Unsigned_in  = ins.uns;
    endtask

    task automatic issue(input instr_t ins, input bit st = 1'b0, input bit fl = 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(ins);
        stall = st;
        flush = fl;
        step(ins, st, fl, 1'b0);
    endtask

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                                  input logic rw, input logic m2r, input logic mr, input logic mw,
                                  input logic [1:0] size, input logic uns);
        instr_t i;
        i.alu = alu; i.wd = wd; i.rd = rd; i.rw = rw; i.m2r = m2r;
        i.mr = mr; i.mw = mw; i.size = size; i.uns = uns;
        return i;
    endfunction

    function automatic instr_t st_i(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        return mk(a, d, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, s, 1'b0);
    endfunction

    function automatic instr_t ld_i(input logic [31:0] a, input logic [1:0] s, input logic u, input logic [4:0] rd);
        return mk(a, $urandom, rd, 1'b1, 1'b1, 1'b1, 1'b0, s, u);
    endfunction

    function automatic instr_t rand_instr();
        return mk($urandom & 32'hFFFF_F03F, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    endfunction

    // Issue a load and check ReadData against a fixed required value once it is in the register
    task automatic ldk(input string nm, input logic [31:0] a, input logic [1:0] s, input logic u,
                       input logic [4:0] rd, input logic [31:0] req);
        issue(ld_i(a, s, u, rd));
        @(posedge clk); #3;
        chk(nm, ReadData, req);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ReadData"}, ReadData, 32'd0);
        chk({nm, "_AluRes"}, AluRes, 32'd0);
        chk({nm, "_Rd"}, 32'(Rd), 32'd0);
        chk({nm, "_RegWrite"}, 32'(RegWrite), 32'd0);
        chk({nm, "_MemToReg"}, 32'(MemToReg), 32'd0);
        chk({nm, "_Misaligned"}, 32'(Misaligned), 32'd0);
    endtask

    // Assert reset in the middle of a cycle; the register must clear before the next edge
    task automatic rst_mid();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'($urandom);
        flush = 1'b0;
        drive(rand_instr());
        step('0, 1'b0, 1'b0, 1'b1);
        #1;
        chk_zero("reset_async");
    endtask

    // Monitor: every edge the register holds exactly one expected entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ReadData",   ReadData,          e.rdata);
                chk("sb_AluRes",     AluRes,            e.alu);
                chk("sb_Rd",         32'(Rd),           32'(e.rd));
                chk("sb_RegWrite",   32'(RegWrite),     32'(e.rw));
                chk("sb_MemToReg",   32'(MemToReg),     32'(e.m2r));
                chk("sb_Misaligned", 32'(Misaligned),   32'(e.mis));
            end
        end
    end

    initial begin : stimulus
        logic [31:0] oldv;
        int          r;
        cur   = '0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive('0);
        #12;
        chk_zero("reset_state");

        // Preload every word so the reference memory is fully known
        for (int w = 0; w < 256; w++) issue(st_i(32'(w * 4), $urandom, 2'd2));

        // Word store then load
        issue(st_i(32'h10, 32'hDEAD_BEEF, 2'd2));
        ldk("tp_word_load", 32'h10, 2'd2, 1'b0, 5'd7, 32'hDEAD_BEEF);
        chk("tp_word_RegWrite", 32'(RegWrite), 32'd1);
        chk("tp_word_MemToReg", 32'(MemToReg), 32'd1);
        chk("tp_word_Rd", 32'(Rd), 32'd7);

        // Byte/half extension
        issue(st_i(32'h20, 32'h80F1_7F01, 2'd2));
        ldk("tp_lb",  32'h22, 2'd0, 1'b0, 5'd1, 32'hFFFF_FFF1);
        ldk("tp_lbu", 32'h22, 2'd0, 1'b1, 5'd2, 32'h0000_00F1);
        ldk("tp_lh",  32'h22, 2'd1, 1'b0, 5'd3, 32'hFFFF_80F1);
        ldk("tp_lhu", 32'h20, 2'd1, 1'b1, 5'd4, 32'h0000_7F01);

        // Sub-word store merge
        issue(st_i(32'h30, 32'h1122_3344, 2'd2));
        issue(st_i(32'h31, 32'h5555_55AA, 2'd0));
        issue(st_i(32'h32, 32'h1234_BEEF, 2'd1));
        ldk("tp_merge", 32'h30, 2'd2, 1'b0, 5'd9, 32'hBEEF_AA44);

        // Misalignment
        issue(st_i(32'h40, 32'h1234_5678, 2'd2));
        issue(ld_i(32'h41, 2'd2, 1'b0, 5'd10));
        @(posedge clk); #3;
        chk("tp_mis_flag", 32'(Misaligned), 32'd1);
        chk("tp_mis_ReadData", ReadData, 32'd0);
        chk("tp_mis_RegWrite", 32'(RegWrite), 32'd0);
        issue(st_i(32'h43, 32'h0000_CAFE, 2'd1));
        @(posedge clk); #3;
        chk("tp_mis_store_flag", 32'(Misaligned), 32'd1);
        ldk("tp_mis_mem_kept", 32'h40, 2'd2, 1'b0, 5'd11, 32'h1234_5678);

        // Stall holds, flush bubbles
        issue(mk(32'h7, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0));
        for (int k = 0; k < 2; k++) begin
            issue(rand_instr(), 1'b1, 1'b0);
            @(posedge clk); #3;
            chk("tp_stall_Rd", 32'(Rd), 32'd5);
            chk("tp_stall_AluRes", AluRes, 32'h7);
        end
        issue(rand_instr(), 1'b0, 1'b1);
        @(posedge clk); #3;
        chk_zero("tp_flush");

        // Reset mid-cycle with a store pending: word must keep its old value
        oldv = {mbytes[83], mbytes[82], mbytes[81], mbytes[80]};
        issue(st_i(32'h50, ~oldv, 2'd2));
        rst_mid();
        ldk("tp_reset_mem_kept", 32'h50, 2'd2, 1'b0, 5'd12, oldv);

        // Address wrap modulo 1 KiB
        issue(st_i(32'h404, 32'hA5C3_0F96, 2'd2));
        ldk("tp_wrap", 32'h004, 2'd2, 1'b0, 5'd13, 32'hA5C3_0F96);

        // Random traffic with occasional stall, flush and reset
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       rst_mid();
            else if (r < 12) issue(rand_instr(), 1'b1, 1'b0);
            else if (r < 18) issue(rand_instr(), 1'b0, 1'b1);
            else             issue(rand_instr());
        end

        repeat (3) @(posedge clk);
        #4;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
